fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller.sv | 106 ++++++++++
 tb/tb_fetch_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch stage: keeps the program counter, registers fetched words into ir,
// and handles stall, absolute jump, relative branch and halt/resume control.
module fetch_controller #(
    parameter int N             = 8,
    parameter int AddrSz        = 6,
    parameter int InstructionSz = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stall,
    input  logic                     jump,
    input  logic [AddrSz-1:0]        target,
    input  logic                     branch,
    input  logic [N-1:0]             offset,
    input  logic                     halt_req,
    input  logic                     resume,
    input  logic [InstructionSz-1:0] instruction,
    output logic [AddrSz-1:0]        address,
    output logic [InstructionSz-1:0] ir,
    output logic [AddrSz-1:0]        ir_pc,
    output logic                     ir_valid,
    output logic                     halted
);

    localparam int ExtW = (N > AddrSz) ? N : AddrSz;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                   state, state_d;
    logic [AddrSz-1:0]        pc, pc_d;
    logic [InstructionSz-1:0] ir_d;
    logic [AddrSz-1:0]        ir_pc_d;
    logic                     ir_valid_d;
    logic [AddrSz-1:0]        branch_pc;
    logic                     branch_taken;

    // Offset is sign-extended before truncation so narrow offsets still move backwards.
    assign branch_pc    = ir_pc + AddrSz'(ExtW'($signed(offset)));
    assign branch_taken = branch && ir_valid;

    assign address = pc;
    assign halted  = (state == HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= '0;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            ir       <= ir_d;
            ir_pc    <= ir_pc_d;
            ir_valid <= ir_valid_d;
        end
    end

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        ir_d       = ir;
        ir_pc_d    = ir_pc;
        ir_valid_d = ir_valid;
        case (state)
            IDLE: begin
                ir_valid_d = 1'b0;
                if (start) state_d = RUN;
            end
            RUN: begin
                // A redirect invalidates ir because the word behind it is on the wrong path.
                if (jump) begin
                    pc_d       = target;
                    ir_valid_d = 1'b0;
                end else if (branch_taken) begin
                    pc_d       = branch_pc;
                    ir_valid_d = 1'b0;
                end else if (!halt_req && !stall) begin
                    ir_d       = instruction;
                    ir_pc_d    = pc;
                    ir_valid_d = 1'b1;
                    pc_d       = pc + 1'b1;
                end
                if (halt_req) begin
                    state_d    = HALT;
                    ir_valid_d = 1'b0;
                end
            end
            HALT: begin
                ir_valid_d = 1'b0;
                if (resume) state_d = RUN;
            end
            default: begin
                state_d    = IDLE;
                ir_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios with literal expectations,
// then randomized control traffic compared every cycle against a behavioural model.
module tb_fetch_controller;

    localparam int Span = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start = 1'b0, stall = 1'b0, jump = 1'b0, branch = 1'b0;
    logic        halt_req = 1'b0, resume = 1'b0;
    logic [5:0]  target = '0;
    logic [7:0]  offset = '0;
    logic [23:0] instruction;
    logic [5:0]  address;
    logic [23:0] ir;
    logic [5:0]  ir_pc;
    logic        ir_valid;
    logic        halted;

    logic [23:0] mem [Span];
    int          tests = 0;
    int          fails = 0;
    logic        check_en = 1'b0;

    // Model: 0 = idle, 1 = fetching, 2 = halted
    int          m_mode = 0;
    int          m_pc = 0;
    int          m_ir_pc = 0;
    logic [23:0] m_ir = '0;
    logic        m_valid = 1'b0;

    fetch_controller #(.N(8), .AddrSz(6), .InstructionSz(24)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .jump(jump),
        .target(target), .branch(branch), .offset(offset), .halt_req(halt_req),
        .resume(resume), .instruction(instruction), .address(address), .ir(ir),
        .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    assign instruction = mem[address];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change just after an edge; returns 1 time unit after the next rising edge.
    task automatic applyStimulus(input logic st, input logic sl, input logic j, input logic [5:0] tg,
                                 input logic br, input logic [7:0] off, input logic hr, input logic rs);
        start = st; stall = sl; jump = j; target = tg;
        branch = br; offset = off; halt_req = hr; resume = rs;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_pc = 0; m_ir_pc = 0; m_ir = '0; m_valid = 1'b0;
        end else begin
            int  next_pc;
            bit  redirect;
            next_pc  = m_pc;
            redirect = 1'b0;
            if (m_mode == 0) begin
                if (start) m_mode = 1;
            end else if (m_mode == 2) begin
                if (resume) m_mode = 1;
            end else begin
                if (jump) begin
                    next_pc = int'(target);
                    redirect = 1'b1;
                end else if (branch && m_valid) begin
                    next_pc = ((m_ir_pc + int'($signed(offset))) % Span + Span) % Span;
                    redirect = 1'b1;
                end
                if (redirect || halt_req) begin
                    m_valid = 1'b0;
                end else if (!stall) begin
                    m_ir    = mem[m_pc];
                    m_ir_pc = m_pc;
                    m_valid = 1'b1;
                    next_pc = (m_pc + 1) % Span;
                end
                m_pc = next_pc;
                if (halt_req) m_mode = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("address", 32'(address), 32'(m_pc));
            checkOutput("ir_valid", 32'(ir_valid), 32'(m_valid));
            checkOutput("halted", 32'(halted), (m_mode == 2) ? 32'd1 : 32'd0);
            if (m_valid) begin
                checkOutput("ir", 32'(ir), 32'(m_ir));
                checkOutput("ir_pc", 32'(ir_pc), 32'(m_ir_pc));
            end
        end
    end

    initial begin
        for (int k = 0; k < Span; k++) mem[k] = 24'(k);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_address", 32'(address), 32'd0);
        checkOutput("reset_ir", 32'(ir), 32'd0);
        checkOutput("reset_ir_valid", 32'(ir_valid), 32'd0);
        checkOutput("reset_halted", 32'(halted), 32'd0);
        reset = 1'b0;
        check_en = 1'b1;

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("idle_halt_ignored", 32'(halted), 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("start_no_fetch", 32'(ir_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("first_ir", 32'(ir), 32'(k));
            checkOutput("first_ir_pc", 32'(ir_pc), 32'(k));
            checkOutput("first_valid", 32'(ir_valid), 32'd1);
        end

        applyStimulus(0, 0, 1, 6'd62, 0, 0, 0, 0);
        checkOutput("jump_bubble", 32'(ir_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("wrap_ir_pc", 32'(ir_pc), (k == 2) ? 32'd0 : 32'(62 + k));
        end
        checkOutput("wrap_address", 32'(address), 32'd1);

        applyStimulus(0, 0, 1, 6'd10, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pre_branch_ir_pc", 32'(ir_pc), 32'd10);
        applyStimulus(0, 0, 0, 0, 1, 8'hFC, 0, 0);
        checkOutput("branch_back_address", 32'(address), 32'd6);
        checkOutput("branch_bubble", 32'(ir_valid), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("branch_target_ir_pc", 32'(ir_pc), 32'd6);
        applyStimulus(0, 0, 1, 6'd60, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 8'h05, 0, 0);
        checkOutput("branch_wrap_address", 32'(address), 32'd1);

        applyStimulus(0, 1, 1, 6'd20, 1, 8'h03, 0, 0);
        checkOutput("priority_address", 32'(address), 32'd20);
        checkOutput("priority_valid", 32'(ir_valid), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
            checkOutput("stall_ir_pc", 32'(ir_pc), 32'd20);
            checkOutput("stall_ir", 32'(ir), 32'd20);
            checkOutput("stall_address", 32'(address), 32'd21);
        end

        applyStimulus(0, 0, 1, 6'd5, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("halt_halted", 32'(halted), 32'd1);
        checkOutput("halt_address", 32'(address), 32'd5);
        applyStimulus(0, 0, 1, 6'd30, 0, 0, 0, 0);
        checkOutput("halt_jump_ignored", 32'(address), 32'd5);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("resume_halted", 32'(halted), 32'd0);
        checkOutput("resume_no_fetch", 32'(ir_valid), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("resume_fetch_ir_pc", 32'(ir_pc), 32'd5);

        applyStimulus(0, 0, 1, 6'd17, 0, 0, 0, 0);
        checkOutput("pre_reset_address", 32'(address), 32'd17);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_address", 32'(address), 32'd0);
        checkOutput("async_reset_valid", 32'(ir_valid), 32'd0);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("post_reset_idle_address", 32'(address), 32'd0);
        end

        for (int k = 0; k < Span; k++) mem[k] = 24'($urandom);
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 9) == 0, 6'($urandom),
                          $urandom_range(0, 9) < 3, 8'($urandom),
                          $urandom_range(0, 99) < 8, $urandom_range(0, 9) < 3);
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
